// File: rtl/cu_multicycle.sv
// Multicycle control unit: fetch/decode/execute/memory/writeback sequencing for a
// small 16-opcode ISA, with sticky illegal-opcode flag and retired-instruction count.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | request instruction at PC, latch opcode when memory is ready
// DECODE | classify opcode, count retirement or flag illegal
// EXEC   | ALU operation / address compute / branch resolution
// MEM    | data load or store at ALU address, wait for memory
// WB     | one-cycle register write from ALU, memory or immediate
// HALT   | parked until reset
module cu_multicycle #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic [OPC_W-1:0]   opcode,
  output logic [2:0]         state,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               reg_we,
  output logic [1:0]         alu_op,
  output logic [1:0]         wb_sel,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_HALT = '1;

  state_t state_q, state_d;

  logic is_alu, is_ldi, is_ld, is_st, is_jmp, is_beq, is_nop, is_halt, is_legal;

  // Operand fields of the instruction word belong to the datapath, not to this block.
  logic instr_operand_unused;
  assign instr_operand_unused = ^instr[INSTR_W-OPC_W-1:0];

  assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign is_ldi   = (opcode == OP_LDI);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_nop   = (opcode == OP_NOP);
  assign is_halt  = (opcode == OP_HALT);
  assign is_legal = is_alu || is_ldi || is_ld || is_st || is_jmp || is_beq ||
                    is_nop || is_halt;

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      opcode      <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && mem_ready)
        opcode <= instr[INSTR_W-1 -: OPC_W];
      if (state_q == S_DECODE) begin
        if (is_legal) instr_count <= instr_count + CNT_W'(1);
        else          illegal     <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    reg_we   = 1'b0;
    alu_op   = 2'b00;
    wb_sel   = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt)                 state_d = S_HALT;
        else if (is_ldi)             state_d = S_WB;
        else if (is_nop || !is_legal) state_d = S_FETCH;
        else                         state_d = S_EXEC;
      end
      S_EXEC: begin
        // BEQ compares by subtraction; address and jump paths use ADD.
        if (opcode == OP_SUB || opcode == OP_BEQ) alu_op = 2'b01;
        else if (opcode == OP_AND)                alu_op = 2'b10;
        else if (opcode == OP_OR)                 alu_op = 2'b11;
        pc_load = is_jmp || (is_beq && alu_zero);
        if (is_alu)              state_d = S_WB;
        else if (is_ld || is_st) state_d = S_MEM;
        else                     state_d = S_FETCH;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_st;
        if (mem_ready) state_d = is_ld ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = is_ld ? 2'b01 : (is_ldi ? 2'b10 : 2'b00);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset abandons any in-flight memory transaction immediately.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      reg_we   = 1'b0;
      alu_op   = 2'b00;
      wb_sel   = 2'b00;
    end
  end

endmodule
